// File: rtl/tau_seq_pkg.sv
// Shared types and encodings for the program-counter sequencer.
//   seq_state_t : sequencer FSM states
//   op_kind_t   : control-flow kind reported by the execute unit.
//                 The decode unit uses the same encoding.
package tau_seq_pkg;

    localparam int OP_KIND_W = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_VECTOR  = 3'd1,
        S_FETCH   = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALTED  = 3'd4,
        S_FAULT   = 3'd5
    } seq_state_t;

    typedef enum logic [OP_KIND_W-1:0] {
        OP_NEXT   = 2'b00,
        OP_JUMP   = 2'b01,
        OP_CALL   = 2'b10,
        OP_RETURN = 2'b11
    } op_kind_t;

endpackage

// File: rtl/return_stack.sv
// Parameterised LIFO that holds return addresses.
//   clock, reset : rising-edge clock; synchronous active-high reset clears level only
//   push, data   : write data on top (ignored when full)
//   pop          : discard top entry (ignored when empty)
//   top          : current top entry (zero when empty)
//   full, empty  : occupancy flags
//   level        : number of valid entries
module return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             data,
    output logic [WIDTH-1:0]             top,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(DEPTH + 1);
    // Entry index width; at least 1 so DEPTH=1 still has a legal index.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    level_q;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    assign wr_idx = IW'(level_q);
    assign rd_idx = IW'(level_q - LW'(1));

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign top   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + LW'(1);
        end else if (pop && !empty) begin
            level_q <= level_q - LW'(1);
        end
    end

    // Contents are not reset; only entries below level are ever read.
    always_ff @(posedge clock) begin
        if (!reset && push && !full) begin
            mem[wr_idx] <= data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Control FSM that steps the program counter through fetch and execute.
//   clock, reset          : rising-edge clock; synchronous active-high reset
//   run                   : start from IDLE, resume from HALTED
//   mem_ready             : instruction word valid for current PC (FETCH only)
//   exec_done             : execute finished; op_* valid this cycle (EXECUTE only)
//   op_kind, op_halt      : control-flow decision; op_halt overrides op_kind
//   target                : jump/call destination
//   pc_value              : counter output
//   pc_load (active low), pc_enable, pc_address : counter controls, acted on
//                           at the edge that ends the decision cycle
//   ir_load               : one-cycle instruction-register strobe
//   busy, halted, fault   : state flags
//   stack_level           : return-stack occupancy
//   dbg_state             : current FSM state for observation
// Handshake: mem_ready and exec_done are level-qualified requests; the
// sequencer consumes each in the first cycle it is seen high in the owning
// state and ignores it in every other state.
module pc_sequencer
    import tau_seq_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = 16,
    parameter int                         STACK_DEPTH   = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                run,
    input  logic                                mem_ready,
    input  logic                                exec_done,
    input  logic [1:0]                          op_kind,
    input  logic                                op_halt,
    input  logic [ADDRESS_WIDTH-1:0]            target,
    input  logic [ADDRESS_WIDTH-1:0]            pc_value,
    output logic                                pc_load,
    output logic                                pc_enable,
    output logic [ADDRESS_WIDTH-1:0]            pc_address,
    output logic                                ir_load,
    output logic                                busy,
    output logic                                halted,
    output logic                                fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0]    stack_level,
    output seq_state_t                          dbg_state
);

    seq_state_t                state, next_state;
    op_kind_t                  kind;
    logic                      push, pop;
    logic                      stk_full, stk_empty;
    logic [ADDRESS_WIDTH-1:0]  stk_top;
    logic [ADDRESS_WIDTH-1:0]  return_addr;

    assign kind        = op_kind_t'(op_kind);
    // Natural wrap: a CALL at the top address returns to 0.
    assign return_addr = pc_value + ADDRESS_WIDTH'(1);

    return_stack #(
        .WIDTH (ADDRESS_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .data  (return_addr),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .level (stack_level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Reset gates the decision logic so a concurrent exec_done or run can
    // neither move the PC nor touch the stack.
    always_comb begin
        next_state = state;
        pc_load    = 1'b1;
        pc_enable  = 1'b0;
        pc_address = RESET_VECTOR;
        ir_load    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (run) next_state = S_VECTOR;
                end
                S_VECTOR: begin
                    pc_load    = 1'b0;
                    next_state = S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_load    = 1'b1;
                        next_state = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (exec_done) begin
                        if (op_halt) begin
                            next_state = S_HALTED;
                        end else begin
                            case (kind)
                                OP_NEXT: begin
                                    pc_enable  = 1'b1;
                                    next_state = S_FETCH;
                                end
                                OP_JUMP: begin
                                    pc_load    = 1'b0;
                                    pc_address = target;
                                    next_state = S_FETCH;
                                end
                                OP_CALL: begin
                                    if (stk_full) begin
                                        next_state = S_FAULT;
                                    end else begin
                                        push       = 1'b1;
                                        pc_load    = 1'b0;
                                        pc_address = target;
                                        next_state = S_FETCH;
                                    end
                                end
                                default: begin // OP_RETURN
                                    if (stk_empty) begin
                                        next_state = S_FAULT;
                                    end else begin
                                        pop        = 1'b1;
                                        pc_load    = 1'b0;
                                        pc_address = stk_top;
                                        next_state = S_FETCH;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_HALTED: begin
                    if (run) begin
                        pc_enable  = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                default: begin // S_FAULT: terminal until reset
                    next_state = S_FAULT;
                end
            endcase
        end
    end

    assign busy      = (state == S_FETCH) || (state == S_EXECUTE);
    assign halted    = (state == S_HALTED);
    assign fault     = (state == S_FAULT);
    assign dbg_state = state;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import tau_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset, run, mem_ready, exec_done, op_halt;
    logic [1:0]  op_kind;
    logic [15:0] target, pc_value;
    logic        pc_load, pc_enable, ir_load, busy, halted, fault;
    logic [15:0] pc_address;
    logic [2:0]  stack_level;
    seq_state_t  dbg_state;

    logic        cnt_clr;
    logic [15:0] pc;
    int          total = 0;
    int          bad   = 0;
    int          ir_cnt = 0, en_cnt = 0, ld_cnt = 0;

    always #5 clock = ~clock;

    pc_sequencer #(.ADDRESS_WIDTH(16), .STACK_DEPTH(4), .RESET_VECTOR(16'h0000)) dut (
        .clock(clock), .reset(reset), .run(run), .mem_ready(mem_ready),
        .exec_done(exec_done), .op_kind(op_kind), .op_halt(op_halt),
        .target(target), .pc_value(pc_value), .pc_load(pc_load),
        .pc_enable(pc_enable), .pc_address(pc_address), .ir_load(ir_load),
        .busy(busy), .halted(halted), .fault(fault),
        .stack_level(stack_level), .dbg_state(dbg_state)
    );

    // Program counter model (counter_w_load): active-low load beats enable.
    always @(posedge clock) begin
        if (cnt_clr)         pc <= 16'hAAAA;
        else if (!pc_load)   pc <= pc_address;
        else if (pc_enable)  pc <= pc + 16'd1;
    end
    assign pc_value = pc;

    always @(posedge clock) begin
        if (ir_load)   ir_cnt++;
        if (pc_enable) en_cnt++;
        if (!pc_load)  ld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH: mem_ready on the second FETCH cycle,
    // exec_done on the second EXECUTE cycle. Returns with the decision
    // inputs applied and combinational outputs settled, before the edge.
    task automatic do_instr(input logic [1:0] k, input logic h, input logic [15:0] t);
        check("fetch_state", 32'(dbg_state), 32'(S_FETCH));
        mem_ready = 1'b0; #1;
        check("fetch_wait_ir", 32'(ir_load), 32'(0));
        @(negedge clock);
        mem_ready = 1'b1; #1;
        check("fetch_ir_load", 32'(ir_load), 32'(1));
        @(negedge clock);
        mem_ready = 1'b0; exec_done = 1'b0; #1;
        check("exec_hold", {30'd0, pc_load, pc_enable}, 32'h2);
        @(negedge clock);
        exec_done = 1'b1; op_kind = k; op_halt = h; target = t; #1;
    endtask

    task automatic finish_exec();
        @(negedge clock);
        exec_done = 1'b0; op_halt = 1'b0; #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; #1;
    endtask

    task automatic start();
        run = 1'b1;
        @(negedge clock);
        run = 1'b0; #1;
        check("vector_load", 32'(pc_load), 32'(0));
        check("vector_addr", 32'(pc_address), 32'h0);
        @(negedge clock); #1;
    endtask

    initial begin
        reset = 1'b1; cnt_clr = 1'b1; run = 1'b0; mem_ready = 1'b0;
        exec_done = 1'b0; op_kind = 2'b00; op_halt = 1'b0; target = 16'h0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_outputs", {25'd0, pc_load, pc_enable, ir_load, busy, halted, fault, 1'b0}, 32'h40);
        check("rst_addr", 32'(pc_address), 32'h0);
        check("rst_level", 32'(stack_level), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        reset = 1'b0; cnt_clr = 1'b0;
        @(negedge clock); #1;
        check("idle_hold", 32'(dbg_state), 32'(S_IDLE));

        // Start: one-cycle vector load to address 0.
        run = 1'b1; #1;
        check("idle_run_no_load", 32'(pc_load), 32'(1));
        @(negedge clock);
        run = 1'b0; #1;
        check("vector_load", 32'(pc_load), 32'(0));
        check("vector_addr", 32'(pc_address), 32'h0);
        @(negedge clock); #1;
        check("pc_after_vector", 32'(pc), 32'h0);
        check("busy_fetch", 32'(busy), 32'(1));

        // Three sequential instructions.
        for (int i = 0; i < 3; i++) begin
            do_instr(2'b00, 1'b0, 16'h0);
            check("next_enable", {30'd0, pc_load, pc_enable}, 32'h3);
            finish_exec();
            check("next_pc", 32'(pc), 32'(i + 1));
        end
        check("ir_count", 32'(ir_cnt), 32'd3);
        check("en_count", 32'(en_cnt), 32'd3);
        check("load_count", 32'(ld_cnt), 32'd1);

        // JUMP 0x0037 at pc=3.
        do_instr(2'b01, 1'b0, 16'h0037);
        check("jump_load", 32'(pc_load), 32'(0));
        check("jump_addr", 32'(pc_address), 32'h0037);
        finish_exec();
        check("jump_pc", 32'(pc), 32'd55);
        check("jump_level", 32'(stack_level), 32'd0);

        // CALL 0x0100 from 0x0010, then RETURN to 0x0011.
        do_instr(2'b01, 1'b0, 16'h0010);
        finish_exec();
        do_instr(2'b10, 1'b0, 16'h0100);
        check("call_addr", {15'd0, pc_load, pc_address}, 32'h0100);
        finish_exec();
        check("call_pc", 32'(pc), 32'h0100);
        check("call_level", 32'(stack_level), 32'd1);
        do_instr(2'b11, 1'b0, 16'h0);
        check("ret_addr", {15'd0, pc_load, pc_address}, 32'h0011);
        finish_exec();
        check("ret_pc", 32'(pc), 32'h0011);
        check("ret_level", 32'(stack_level), 32'd0);

        // CALL at 0xFFFF pushes 0x0000.
        do_instr(2'b01, 1'b0, 16'hFFFF);
        finish_exec();
        do_instr(2'b10, 1'b0, 16'h0200);
        finish_exec();
        check("wrapcall_pc", 32'(pc), 32'h0200);
        do_instr(2'b11, 1'b0, 16'h0);
        check("wrapret_addr", {15'd0, pc_load, pc_address}, 32'h0000);
        finish_exec();
        check("wrapret_pc", 32'(pc), 32'h0);

        // Four nested CALLs fill the stack; the fifth faults.
        for (int i = 0; i < 4; i++) begin
            do_instr(2'b10, 1'b0, 16'h0300 + 16'(i));
            finish_exec();
            check("nest_level", 32'(stack_level), 32'(i + 1));
        end
        do_instr(2'b10, 1'b0, 16'h0304);
        check("ovf_no_load", {30'd0, pc_load, pc_enable}, 32'h2);
        finish_exec();
        check("ovf_fault", 32'(fault), 32'(1));
        check("ovf_pc", 32'(pc), 32'h0303);
        check("ovf_level", 32'(stack_level), 32'd4);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0; #1;
        check("fault_sticky", 32'(dbg_state), 32'(S_FAULT));
        do_reset();
        check("fault_cleared", {29'd0, fault, halted, busy}, 32'h0);
        check("reset_level", 32'(stack_level), 32'd0);

        // RETURN on an empty stack from a fresh start.
        start();
        do_instr(2'b11, 1'b0, 16'h0);
        check("udf_no_load", 32'(pc_load), 32'(1));
        finish_exec();
        check("udf_fault", 32'(fault), 32'(1));
        check("udf_pc", 32'(pc), 32'h0);
        do_reset();

        // HALT overrides JUMP; run steps past it.
        start();
        do_instr(2'b01, 1'b1, 16'h0055);
        check("halt_no_load", {30'd0, pc_load, pc_enable}, 32'h2);
        finish_exec();
        check("halted", {29'd0, halted, busy, fault}, 32'h4);
        check("halt_pc", 32'(pc), 32'h0);
        @(negedge clock); #1;
        check("halt_wait", 32'(dbg_state), 32'(S_HALTED));
        run = 1'b1; #1;
        check("resume_enable", {30'd0, pc_load, pc_enable}, 32'h3);
        @(negedge clock);
        run = 1'b0; #1;
        check("resume_state", 32'(dbg_state), 32'(S_FETCH));
        check("resume_pc", 32'(pc), 32'h1);

        // Reset in the same cycle as exec_done: no PC change.
        do_instr(2'b01, 1'b0, 16'h0077);
        reset = 1'b1; #1;
        check("rst_exec_load", 32'(pc_load), 32'(1));
        @(negedge clock);
        reset = 1'b0; exec_done = 1'b0; #1;
        check("rst_exec_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_exec_pc", 32'(pc), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that sequences the program counter (counter_w_load) through fetch and execute.
- Drives the counter's load, enable and address inputs. Fetches an instruction word, waits for execute completion, then advances, jumps, calls or returns.
- Holds a small hardware return-address stack for CALL/RETURN.
- Sits between instruction memory, the decode/execute unit and the program counter.

Parameters:
- ADDRESS_WIDTH, 16, width of PC and all address ports.
- STACK_DEPTH, 4, number of return-address stack entries (>=1).
- RESET_VECTOR, 0, address loaded into the PC when leaving IDLE.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  start from IDLE; resume from HALTED.
- mem_ready  input  1  instruction memory output valid for current PC.
- exec_done  input  1  execute unit has finished the current instruction; op_* are valid this cycle.
- op_kind  input  2  00 NEXT, 01 JUMP, 10 CALL, 11 RETURN.
- op_halt  input  1  current instruction is HALT; overrides op_kind.
- target  input  ADDRESS_WIDTH  jump/call destination.
- pc_value  input  ADDRESS_WIDTH  current counter data output.
- pc_load  output  1  active-low to counter: 0 = parallel load of pc_address on next edge.
- pc_enable  output  1  counter increment enable; never 1 while pc_load=0.
- pc_address  output  ADDRESS_WIDTH  load value for counter.
- ir_load  output  1  one-cycle strobe to latch instruction register.
- busy  output  1  state is FETCH or EXECUTE.
- halted  output  1  state is HALTED.
- fault  output  1  state is FAULT.
- stack_level  output  $clog2(STACK_DEPTH+1)  current stack occupancy.

Behaviour:
- Reset (highest priority, overrides exec_done/run in same cycle):
  - state=IDLE, sp=0, stack contents don't-care.
  - Outputs: pc_load=1, pc_enable=0, pc_address=RESET_VECTOR, ir_load=0, busy=0, halted=0, fault=0.
- Output timing:
  - pc_load, pc_enable, pc_address and ir_load are combinational from state and inputs.
  - The counter acts on the edge ending the decision cycle, so PC change latency is 1 edge.
  - Default each cycle: pc_load=1, pc_enable=0, pc_address=RESET_VECTOR.
- States: IDLE, VECTOR, FETCH, EXECUTE, HALTED, FAULT.
- IDLE: run=1 -> VECTOR; else stay.
- VECTOR: pc_load=0, pc_address=RESET_VECTOR for exactly one cycle -> FETCH.
- FETCH: wait for mem_ready. When mem_ready=1: ir_load=1 that cycle -> EXECUTE. The PC is held throughout FETCH.
- EXECUTE: hold until exec_done=1. Then, evaluated in this order:
  - op_halt=1 -> HALTED, PC unchanged.
  - NEXT: pc_enable=1 -> FETCH.
  - JUMP: pc_load=0, pc_address=target -> FETCH.
  - CALL, sp<STACK_DEPTH: push (pc_value+1) mod 2^ADDRESS_WIDTH (return address wraps from max to 0), sp+1; pc_load=0, pc_address=target -> FETCH.
  - CALL, sp==STACK_DEPTH: overflow -> FAULT; no push, PC unchanged.
  - RETURN, sp>0: pop top, sp-1; pc_load=0, pc_address=popped -> FETCH.
  - RETURN, sp==0: underflow -> FAULT; PC unchanged.
- HALTED: run=1 -> pc_enable=1 (step past HALT) -> FETCH.
- FAULT: terminal; only reset exits.
- Ignored inputs:
  - run is ignored outside IDLE/HALTED.
  - mem_ready is ignored outside FETCH.
  - exec_done is ignored outside EXECUTE.
- Invariants:
  - pc_enable=1 implies pc_load=1.
  - ir_load is exactly one pulse per instruction.
  - The stack is never written in FAULT.

Decomposition:
- Package tau_seq_pkg:
  - seq_state_t enum.
  - op_kind_t enum (OP_NEXT, OP_JUMP, OP_CALL, OP_RETURN).
  - Encoding constants shared with the decode unit.
- Sub-module return_stack: parameterised LIFO with push, pop, full, empty, top and level outputs; synchronous reset clears level.

Test Plan:
- reset, then run=1 for 1 cycle -> pc_load=0 with address 0 for one cycle; ir_load after mem_ready; counter data==0.
- 3x NEXT with mem_ready on second FETCH cycle -> pc_enable pulses 3 times; PC 0->1->2->3; ir_load count==3; no pc_load.
- JUMP target=0x0037 at pc=3 -> pc_load=0, pc_address=0x0037; counter data==55 after edge; stack_level=0.
- CALL 0x0100 at pc=0x0010, then RETURN -> stack_level 1 then 0; PC 0x0100 then 0x0011. CALL at pc=0xFFFF pushes 0x0000.
- 5 nested CALLs with STACK_DEPTH=4 -> fifth gives fault=1, PC unchanged. RETURN at sp=0 from fresh start -> fault=1. reset clears fault.
- op_halt with op_kind=JUMP -> halted=1, PC unchanged; run -> PC+1, FETCH. reset asserted with exec_done=1 -> IDLE, no PC change.
